debounce_edge_detect: RTL and testbench

// - Downstream consumer of the 3-stage synchronizer output: takes the already-synchronized level SYNC_IN.
// - Filters glitches by requiring STABLE_CYCLES consecutive equal samples before the debounced level DB_OUT changes.
// - Emits one-cycle RISE_PULSE / FALL_PULSE on each debounced transition.
// - Keeps a wrapping count of debounced falling edges for button/strobe style inputs.
//

---
 rtl/debounce_edge_detect_pkg.sv | 17 +
 rtl/debounce_edge_detect_if.sv | 26 ++
 rtl/debounce_edge_detect_stable_filter.sv | 84 ++++++++
 rtl/debounce_edge_detect.sv | 63 ++++++
 tb/tb_debounce_edge_detect.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/debounce_edge_detect_pkg.sv
// Shared types and helpers for the debounce / edge-detect block.
// Latency: none (declarations only).
// Backpressure: none.
package debounce_edge_detect_pkg;

   // Qualification FSM states; STABLE must stay the reset encoding.
   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } dbc_state_e;

   // Width of the qualification counter: it must hold up to STABLE_CYCLES.
   function automatic int dbc_cnt_width(input int stable_cycles);
      return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
   endfunction

endpackage

// File: rtl/debounce_edge_detect_if.sv
// Bundles the level input, count clear and all debounced outputs.
// Latency: none (wires only).
// Backpressure: none; every signal is a plain level or one-cycle strobe.
interface debounce_edge_detect_if #(
   parameter int CNT_W = 8
);
   logic             sync_in;
   logic             clr_count;
   logic             db_out;
   logic             rise_pulse;
   logic             fall_pulse;
   logic             busy;
   logic [CNT_W-1:0] edge_count;

   // Producer of the raw level and consumer of the debounced results.
   modport master (
      output sync_in, clr_count,
      input  db_out, rise_pulse, fall_pulse, busy, edge_count
   );

   // The debouncer itself.
   modport slave (
      input  sync_in, clr_count,
      output db_out, rise_pulse, fall_pulse, busy, edge_count
   );
endinterface

// File: rtl/debounce_edge_detect_stable_filter.sv
// Qualifies a level: flips db_out after STABLE_CYCLES consecutive mismatching samples.
// Latency: db_out flips on the STABLE_CYCLES-th edge sampling the new level; flip/level_nxt are combinational.
// Backpressure: none; sync_in is sampled every cycle.
module stable_filter
   import debounce_edge_detect_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter bit RESET_LEVEL   = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sync_in,
   output logic db_out,
   output logic busy,
   output logic flip,
   output logic level_nxt
);
   localparam int             CW       = dbc_cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   dbc_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          db_q, db_d;

   // Next-state logic: count consecutive mismatches, drop back on any glitch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      db_d    = db_q;
      flip    = 1'b0;
      case (state_q)
         ST_STABLE: begin
            if (sync_in != db_q) begin
               if (STABLE_CYCLES == 1) begin
                  flip  = 1'b1;
                  db_d  = ~db_q;
                  cnt_d = '0;
               end else begin
                  state_d = ST_PENDING;
                  cnt_d   = CNT_ONE;
               end
            end else begin
               cnt_d = '0;
            end
         end
         ST_PENDING: begin
            if (sync_in == db_q) begin
               state_d = ST_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               flip    = 1'b1;
               db_d    = ~db_q;
               state_d = ST_STABLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_STABLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counter and qualified level registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_STABLE;
         cnt_q   <= '0;
         db_q    <= RESET_LEVEL;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
      end
   end

   assign db_out    = db_q;
   assign busy      = (state_q == ST_PENDING);
   assign level_nxt = db_d;

endmodule

// File: rtl/debounce_edge_detect.sv
// Debounces a synchronized level, emits rise/fall pulses and counts debounced falls.
// Latency: outputs registered; change on the STABLE_CYCLES-th edge sampling a new level.
// Backpressure: none; clr_count is a synchronous clear that beats a coincident fall.
module debounce_edge_detect
   import debounce_edge_detect_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter bit RESET_LEVEL   = 1'b1,
   parameter int CNT_W         = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   debounce_edge_detect_if.slave bus
);
   logic             flip;
   logic             level_nxt;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] edge_count_q, edge_count_d;

   stable_filter #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_LEVEL   (RESET_LEVEL)
   ) u_filter (
      .clk       (clk),
      .rst_n     (rst_n),
      .sync_in   (bus.sync_in),
      .db_out    (bus.db_out),
      .busy      (bus.busy),
      .flip      (flip),
      .level_nxt (level_nxt)
   );

   // Pulse direction follows the new level; the fall counter wraps naturally.
   always_comb begin
      rise_d       = flip & level_nxt;
      fall_d       = flip & ~level_nxt;
      edge_count_d = edge_count_q;
      if (bus.clr_count) begin
         edge_count_d = '0;
      end else if (fall_d) begin
         edge_count_d = edge_count_q + CNT_W'(1);
      end
   end

   // Pulses register on the same edge the filter flips its level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_q       <= 1'b0;
         fall_q       <= 1'b0;
         edge_count_q <= '0;
      end else begin
         rise_q       <= rise_d;
         fall_q       <= fall_d;
         edge_count_q <= edge_count_d;
      end
   end

   assign bus.rise_pulse = rise_q;
   assign bus.fall_pulse = fall_q;
   assign bus.edge_count = edge_count_q;

endmodule

// File: tb/tb_debounce_edge_detect.sv
module tb_debounce_edge_detect;

   // Two instances: index 0 = STABLE_CYCLES 4 / CNT_W 2, index 1 = STABLE_CYCLES 1 / CNT_W 8.
   localparam int SC0 = 4;
   localparam int CW0 = 2;
   localparam int SC1 = 1;
   localparam int CW1 = 8;

   typedef struct {
      bit db;
      bit rise;
      bit fall;
      bit busy;
      int cnt;
   } exp_t;

   logic clk;
   logic rst_n;
   logic sync_in;
   logic clr_count;

   debounce_edge_detect_if #(.CNT_W(CW0)) bus0 ();
   debounce_edge_detect_if #(.CNT_W(CW1)) bus1 ();

   assign bus0.sync_in   = sync_in;
   assign bus0.clr_count = clr_count;
   assign bus1.sync_in   = sync_in;
   assign bus1.clr_count = clr_count;

   debounce_edge_detect #(.STABLE_CYCLES(SC0), .RESET_LEVEL(1'b1), .CNT_W(CW0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   debounce_edge_detect #(.STABLE_CYCLES(SC1), .RESET_LEVEL(1'b1), .CNT_W(CW1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t q0[$];
   exp_t q1[$];

   // Reference model: debounced level plus length of the current run of samples
   // that disagree with it; a run reaching the threshold flips the level.
   bit m_db  [2];
   int m_run [2];
   int m_cnt [2];
   int m_sc  [2];
   int m_mod [2];

   function automatic void cmp(string nm, int act, int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: actual %0d required %0d at %0t", nm, act, req, $time);
      end
   endfunction

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         m_db[d]  = 1'b1;
         m_run[d] = 0;
         m_cnt[d] = 0;
      end
   endfunction

   function automatic void push_exp(int d, bit rise, bit fall);
      exp_t e;
      e.db   = m_db[d];
      e.rise = rise;
      e.fall = fall;
      e.busy = (m_run[d] > 0);
      e.cnt  = m_cnt[d];
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endfunction

   function automatic void model_edge(bit s, bit clr);
      for (int d = 0; d < 2; d++) begin
         bit rise = 1'b0;
         bit fall = 1'b0;
         if (s != m_db[d]) begin
            m_run[d]++;
            if (m_run[d] == m_sc[d]) begin
               m_db[d]  = s;
               m_run[d] = 0;
               rise     = s;
               fall     = !s;
            end
         end else begin
            m_run[d] = 0;
         end
         if (clr)       m_cnt[d] = 0;
         else if (fall) m_cnt[d] = (m_cnt[d] + 1) % m_mod[d];
         push_exp(d, rise, fall);
      end
   endfunction

   // Monitor: one registered result per clock, checked mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            cmp("sc4_db_out",     int'(bus0.db_out),     int'(e.db));
            cmp("sc4_rise_pulse", int'(bus0.rise_pulse), int'(e.rise));
            cmp("sc4_fall_pulse", int'(bus0.fall_pulse), int'(e.fall));
            cmp("sc4_busy",       int'(bus0.busy),       int'(e.busy));
            cmp("sc4_edge_count", int'(bus0.edge_count), e.cnt);
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            cmp("sc1_db_out",     int'(bus1.db_out),     int'(e.db));
            cmp("sc1_rise_pulse", int'(bus1.rise_pulse), int'(e.rise));
            cmp("sc1_fall_pulse", int'(bus1.fall_pulse), int'(e.fall));
            cmp("sc1_busy",       int'(bus1.busy),       int'(e.busy));
            cmp("sc1_edge_count", int'(bus1.edge_count), e.cnt);
         end
      end
   end

   // One clock of stimulus; entered and left 1 ns after a rising edge.
   task automatic step(input bit s, input bit clr);
      sync_in   = s;
      clr_count = clr;
      @(posedge clk);
      model_edge(s, clr);
      #1;
   endtask

   task automatic hold(input bit s, input int n);
      for (int i = 0; i < n; i++) step(s, 1'b0);
   endtask

   // Assert reset between edges, check it took effect without a clock, hold it
   // for ncyc edges (sync_in = lvl_a then lvl_b), then release.
   task automatic do_reset(input int ncyc, input bit lvl_a, input bit lvl_b);
      @(negedge clk);
      #1;
      rst_n     = 1'b0;
      clr_count = 1'b0;
      model_reset();
      #1;
      cmp("rst_now_sc4_busy",  int'(bus0.busy),       0);
      cmp("rst_now_sc4_db",    int'(bus0.db_out),     int'(m_db[0]));
      cmp("rst_now_sc4_rise",  int'(bus0.rise_pulse), 0);
      cmp("rst_now_sc4_fall",  int'(bus0.fall_pulse), 0);
      cmp("rst_now_sc4_count", int'(bus0.edge_count), 0);
      cmp("rst_now_sc1_db",    int'(bus1.db_out),     int'(m_db[1]));
      for (int i = 0; i < ncyc; i++) begin
         sync_in = (i < ncyc / 2) ? lvl_a : lvl_b;
         @(posedge clk);
         push_exp(0, 1'b0, 1'b0);
         push_exp(1, 1'b0, 1'b0);
         #1;
      end
      rst_n = 1'b1;
   endtask

   initial begin
      m_sc[0]  = SC0;
      m_sc[1]  = SC1;
      m_mod[0] = 1 << CW0;
      m_mod[1] = 1 << CW1;
      model_reset();
      rst_n     = 1'b0;
      sync_in   = 1'b1;
      clr_count = 1'b0;

      // Reset with the input moving underneath it.
      do_reset(4, 1'b1, 1'b0);
      hold(1'b1, 3);

      // Glitch: three low samples are not enough.
      hold(1'b0, 3);
      hold(1'b1, 3);

      // Clean fall then clean rise.
      hold(1'b0, 10);
      hold(1'b1, 10);

      // Reset in the middle of a pending fall, then a fresh qualification.
      hold(1'b0, 2);
      do_reset(2, 1'b0, 1'b0);
      hold(1'b0, 6);
      hold(1'b1, 6);

      // Four qualified falls walk the 2-bit counter through a wrap.
      for (int i = 0; i < 4; i++) begin
         hold(1'b0, 5);
         hold(1'b1, 5);
      end

      // Clear coincident with a qualified fall, then a lone clear.
      hold(1'b0, 3);
      step(1'b0, 1'b1);
      hold(1'b0, 2);
      hold(1'b1, 5);
      step(1'b1, 1'b1);

      // Toggle every two cycles.
      for (int i = 0; i < 4; i++) begin
         hold(1'b0, 2);
         hold(1'b1, 2);
      end

      // Random runs of varying length with occasional clears and one reset.
      for (int b = 0; b < 60; b++) begin
         bit lvl = 1'($urandom_range(0, 1));
         int len = $urandom_range(1, 7);
         if (b == 30) do_reset(2, lvl, lvl);
         for (int i = 0; i < len; i++) begin
            step(lvl, ($urandom_range(0, 11) == 0));
         end
      end

      // Drain the scoreboard.
      clr_count = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      cmp("sc4_queue_left", q0.size(), 0);
      cmp("sc1_queue_left", q1.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
